mss_abs_scheduler: RTL and testbench

//  Shares one saturating absolute-value converter between the left (ch0) and

---
 rtl/mss_abs_scheduler.sv | 132 +++++++++++++
 tb/tb_mss_abs_scheduler.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mss_abs_scheduler.sv
// Shared saturating |x| converter for the two MSS microphone streams.
// A round-robin arbiter picks one channel per cycle. The result leaves on a
// registered valid/ready stream tagged with its channel. Per-channel peaks are
// held over windows of WINDOW accepted samples.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   ch0_data/valid/ready  left sample stream (two's complement)
//   ch1_data/valid/ready  right sample stream (two's complement)
//   out_data/ch/valid     registered |sample| (0..32767), source channel, valid
//   out_ready             consumer handshake
//   peak_l/peak_r         per-channel peaks of the last completed window
//   peak_stb              one-cycle pulse when peak_l/peak_r update
module mss_abs_scheduler #(
  parameter int unsigned WINDOW = 1024,
  parameter int unsigned CNT_W  = $clog2(WINDOW)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] ch0_data,
  input  logic        ch0_valid,
  output logic        ch0_ready,
  input  logic [15:0] ch1_data,
  input  logic        ch1_valid,
  output logic        ch1_ready,
  output logic [15:0] out_data,
  output logic        out_ch,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] peak_l,
  output logic [15:0] peak_r,
  output logic        peak_stb
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW - 1);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state, state_next;
  logic             last_grant;
  logic             slot_free, cand, grant0, grant1, accept;
  logic [15:0]      sel_data, abs_val;
  logic [15:0]      run_l, run_r, new_l, new_r;
  logic [CNT_W-1:0] win_cnt;

  // Arbitration: lone valid channel wins; on a tie the channel not served last wins
  always_comb begin
    slot_free = (state == EMPTY) | out_ready;
    if (ch0_valid & ch1_valid) cand = ~last_grant;
    else                       cand = ch1_valid;
    grant0 = slot_free & ch0_valid & ~cand;
    grant1 = slot_free & ch1_valid & cand;
    accept = grant0 | grant1;
  end

  assign ch0_ready = grant0;
  assign ch1_ready = grant1;

  // Saturating absolute value; -32768 clamps to 32767
  always_comb begin
    sel_data = grant1 ? ch1_data : ch0_data;
    if (!sel_data[15])             abs_val = sel_data;
    else if (sel_data == 16'h8000) abs_val = 16'h7FFF;
    else                           abs_val = ~sel_data + 16'd1;
  end

  // Output slot state register
  always_ff @(posedge clk) begin
    if (reset) state <= EMPTY;
    else       state <= state_next;
  end

  // Output slot next state: refilled on any accept, drained when consumed
  always_comb begin
    state_next = state;
    case (state)
      EMPTY:   if (accept) state_next = FULL;
      FULL:    if (out_ready & ~accept) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  assign out_valid = (state == FULL);

  // Output payload and round-robin history
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data   <= 16'd0;
      out_ch     <= 1'b0;
      last_grant <= 1'b1;
    end else if (accept) begin
      out_data   <= abs_val;
      out_ch     <= grant1;
      last_grant <= grant1;
    end
  end

  // Running maxima including the sample being accepted this cycle
  always_comb begin
    new_l = (grant0 && (abs_val > run_l)) ? abs_val : run_l;
    new_r = (grant1 && (abs_val > run_r)) ? abs_val : run_r;
  end

  // Peak window: publish and restart when the last sample of a window is accepted
  always_ff @(posedge clk) begin
    if (reset) begin
      run_l    <= 16'd0;
      run_r    <= 16'd0;
      peak_l   <= 16'd0;
      peak_r   <= 16'd0;
      peak_stb <= 1'b0;
      win_cnt  <= '0;
    end else begin
      peak_stb <= 1'b0;
      if (accept) begin
        if (win_cnt == CNT_LAST) begin
          peak_l   <= new_l;
          peak_r   <= new_r;
          peak_stb <= 1'b1;
          run_l    <= 16'd0;
          run_r    <= 16'd0;
          win_cnt  <= '0;
        end else begin
          run_l   <= new_l;
          run_r   <= new_r;
          win_cnt <= win_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_mss_abs_scheduler.sv
// Bench for mss_abs_scheduler (WINDOW=4): directed cases with literal
// expectations plus a random phase checked cycle-by-cycle against a
// transaction-level model and per-channel ordering scoreboards.
module tb_mss_abs_scheduler;

  localparam int unsigned WIN = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] ch0_data, ch1_data;
  logic        ch0_valid, ch1_valid, ch0_ready, ch1_ready;
  logic [15:0] out_data, peak_l, peak_r;
  logic        out_ch, out_valid, out_ready, peak_stb;

  mss_abs_scheduler #(.WINDOW(WIN)) dut (
    .clk(clk), .reset(reset),
    .ch0_data(ch0_data), .ch0_valid(ch0_valid), .ch0_ready(ch0_ready),
    .ch1_data(ch1_data), .ch1_valid(ch1_valid), .ch1_ready(ch1_ready),
    .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid),
    .out_ready(out_ready),
    .peak_l(peak_l), .peak_r(peak_r), .peak_stb(peak_stb)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] absf(input logic [15:0] d);
    int v;
    v = int'($signed(d));
    if (v < 0) v = -v;
    if (v > 32767) v = 32767;
    return 16'(v);
  endfunction

  // ---------------- model (transaction level) ----------------
  bit          started = 1'b0;
  bit          m_full, m_ch, m_last, m_stb, m_acc0, m_acc1;
  logic [15:0] m_data, m_run_l, m_run_r, m_pk_l, m_pk_r;
  int          m_cnt;
  int          acc_total = 0;
  logic [15:0] q0[$];
  logic [15:0] q1[$];

  // Which channel the slot is handed to this cycle, from the arbitration rules
  function automatic void exp_ready(output bit r0, output bit r1);
    bit free, want1;
    free  = !m_full || out_ready;
    want1 = (ch0_valid && ch1_valid) ? !m_last : ch1_valid;
    r0 = free && ch0_valid && !want1;
    r1 = free && ch1_valid && want1;
  endfunction

  always @(posedge clk) begin
    bit r0, r1;
    logic [15:0] a;
    if (reset) begin
      started = 1'b1;
      m_full = 0; m_ch = 0; m_last = 1; m_stb = 0; m_acc0 = 0; m_acc1 = 0;
      m_data = 0; m_run_l = 0; m_run_r = 0; m_pk_l = 0; m_pk_r = 0; m_cnt = 0;
      q0.delete(); q1.delete();
    end else if (started) begin
      exp_ready(r0, r1);
      m_acc0 = r0; m_acc1 = r1; m_stb = 0;
      if (r0 || r1) begin
        a = absf(r1 ? ch1_data : ch0_data);
        m_full = 1; m_data = a; m_ch = r1; m_last = r1;
        acc_total++;
        if (r1) begin q1.push_back(a); if (a > m_run_r) m_run_r = a; end
        else    begin q0.push_back(a); if (a > m_run_l) m_run_l = a; end
        if (m_cnt == WIN - 1) begin
          m_pk_l = m_run_l; m_pk_r = m_run_r;
          m_run_l = 0; m_run_r = 0; m_cnt = 0; m_stb = 1;
        end else m_cnt++;
      end else if (out_ready) m_full = 0;
    end
  end

  // Compare process: every cycle, away from the active edge
  always @(negedge clk) begin
    bit r0, r1;
    logic [15:0] e;
    if (started) begin
      exp_ready(r0, r1);
      chk("out_valid", 32'(out_valid), 32'(m_full));
      if (m_full) begin
        chk("out_data", 32'(out_data), 32'(m_data));
        chk("out_ch", 32'(out_ch), 32'(m_ch));
      end
      chk("peak_l", 32'(peak_l), 32'(m_pk_l));
      chk("peak_r", 32'(peak_r), 32'(m_pk_r));
      chk("peak_stb", 32'(peak_stb), 32'(m_stb));
      chk("ch0_ready", 32'(ch0_ready), 32'(r0));
      chk("ch1_ready", 32'(ch1_ready), 32'(r1));
      if (!reset && m_full && out_ready) begin
        if (m_ch ? (q1.size() == 0) : (q0.size() == 0)) begin
          chk("sb_underflow", 32'(1), 32'(0));
        end else begin
          e = m_ch ? q1.pop_front() : q0.pop_front();
          chk("sb_order", 32'(out_data), 32'(e));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1; ch0_valid = 0; ch1_valid = 0; out_ready = 0;
    tick(); tick();
    reset = 0;
  endtask

  function automatic logic [15:0] rnd_sample();
    case ($urandom_range(0, 7))
      0: return 16'h8000;
      1: return 16'h7FFF;
      2: return 16'h0000;
      3: return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; ch0_valid = 0; ch1_valid = 0; out_ready = 0;
    ch0_data = 0; ch1_data = 0;
    tick(); tick();
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_ch", 32'(out_ch), 0);
    chk("rst_pk_l", 32'(peak_l), 0);
    chk("rst_pk_r", 32'(peak_r), 0);
    chk("rst_stb", 32'(peak_stb), 0);
    reset = 0;

    // 1: ch0 only, back-to-back
    out_ready = 1; ch0_valid = 1; ch0_data = 16'hFFFB;
    #1 chk("t1_rdy0", 32'(ch0_ready), 1);
    tick(); chk("t1_d0", 32'(out_data), 5);
    ch0_data = 16'h0007;
    tick(); chk("t1_d1", 32'(out_data), 7);
    ch0_data = 16'h8000;
    tick(); chk("t1_d2", 32'(out_data), 16'h7FFF); chk("t1_ch", 32'(out_ch), 0);
    ch0_valid = 0;
    tick(); chk("t1_empty", 32'(out_valid), 0);

    // 2: both valid, alternating grants starting at ch0
    do_reset();
    out_ready = 1; ch0_valid = 1; ch1_valid = 1;
    ch0_data = 16'hFF9C; ch1_data = 16'd200;
    #1 chk("t2_rdy0", 32'(ch0_ready), 1); chk("t2_rdy1", 32'(ch1_ready), 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t2_ch", 32'(out_ch), 32'(i % 2));
      chk("t2_data", 32'(out_data), (i % 2) ? 200 : 100);
    end
    chk("t2_stb", 32'(peak_stb), 1);
    chk("t2_pk_l", 32'(peak_l), 100);
    chk("t2_pk_r", 32'(peak_r), 200);
    ch0_valid = 0; ch1_valid = 0;
    tick(); chk("t2_stb_off", 32'(peak_stb), 0);

    // 3: backpressure
    do_reset();
    ch0_valid = 1; ch0_data = 16'd10;
    tick();
    ch0_data = 16'd11; ch1_valid = 1; ch1_data = 16'd12;
    repeat (3) begin
      #1;
      chk("t3_rdy0", 32'(ch0_ready), 0);
      chk("t3_rdy1", 32'(ch1_ready), 0);
      chk("t3_hold", 32'(out_data), 10);
      tick();
    end
    out_ready = 1;
    #1 chk("t3_rdy1_go", 32'(ch1_ready), 1);
    tick(); chk("t3_d1", 32'(out_data), 12); chk("t3_ch1", 32'(out_ch), 1);
    ch1_valid = 0;
    tick(); chk("t3_d0", 32'(out_data), 11); chk("t3_ch0", 32'(out_ch), 0);
    ch0_valid = 0;
    tick();

    // 4: peak window of 4
    do_reset();
    out_ready = 1; ch0_valid = 1; ch0_data = 16'hFFFD;
    tick(); ch0_data = 16'd9;
    tick(); ch0_valid = 0; ch1_valid = 1; ch1_data = 16'hFFEC;
    tick(); ch1_data = 16'd4;
    tick(); ch1_valid = 0;
    chk("t4_stb", 32'(peak_stb), 1);
    chk("t4_pk_l", 32'(peak_l), 9);
    chk("t4_pk_r", 32'(peak_r), 20);
    tick(); chk("t4_stb_off", 32'(peak_stb), 0); chk("t4_hold", 32'(peak_l), 9);
    ch0_valid = 1;
    for (int i = 0; i < 4; i++) begin
      ch0_data = (i == 3) ? 16'd1 : 16'(i + 1);
      tick();
    end
    ch0_valid = 0;
    chk("t4b_stb", 32'(peak_stb), 1);
    chk("t4b_pk_l", 32'(peak_l), 3);
    chk("t4b_pk_r", 32'(peak_r), 0);

    // 5: reset while FULL with ch1 pending
    out_ready = 0; ch0_valid = 1; ch0_data = 16'd50;
    tick();
    ch0_valid = 0; ch1_valid = 1; ch1_data = 16'd60;
    #1 chk("t5_blocked", 32'(ch1_ready), 0);
    reset = 1;
    tick();
    chk("t5_valid", 32'(out_valid), 0);
    chk("t5_pk_l", 32'(peak_l), 0);
    chk("t5_pk_r", 32'(peak_r), 0);
    reset = 0; ch0_valid = 1; ch0_data = 16'd70; out_ready = 1;
    #1 chk("t5_rdy0", 32'(ch0_ready), 1); chk("t5_rdy1", 32'(ch1_ready), 0);
    tick(); chk("t5_data", 32'(out_data), 70); chk("t5_ch", 32'(out_ch), 0);
    ch0_valid = 0; ch1_valid = 0;
    tick();

    // 6: random traffic, sources hold unaccepted samples
    begin
      int base, cyc;
      base = acc_total;
      cyc = 0;
      while ((acc_total - base) < 10000 && cyc < 60000) begin
        if (!ch0_valid || m_acc0) begin
          ch0_valid = ($urandom_range(0, 9) < 7);
          ch0_data  = rnd_sample();
        end
        if (!ch1_valid || m_acc1) begin
          ch1_valid = ($urandom_range(0, 9) < 7);
          ch1_data  = rnd_sample();
        end
        out_ready = ($urandom_range(0, 3) != 0);
        tick();
        cyc++;
      end
      chk("t6_budget", 32'((acc_total - base) >= 10000), 1);
    end
    ch0_valid = 0; ch1_valid = 0; out_ready = 1;
    tick(); tick();
    chk("t6_q0_drained", 32'(q0.size()), 0);
    chk("t6_q1_drained", 32'(q1.size()), 0);
    chk("t6_empty", 32'(out_valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
